regfile_mp: RTL and testbench

//  Parametrised multi-port integer register file, successor to the 2R1W core regfile.

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/regfile_clr_fsm.sv | 96 +++++++++
 rtl/regfile_mp.sv | 139 +++++++++++++
 tb/tb_regfile_mp.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Shared types and constants for the multi-port register file.
//   - clr_state_e : states of the sequential bulk-clear engine
//   - MAX_NWR     : largest supported number of write ports
//   - addr_w()    : address width for a given register count
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int MAX_NWR = 4;

  typedef enum logic [1:0] {
    CLR_IDLE = 2'd0,
    CLR_RUN  = 2'd1,
    CLR_DONE = 2'd2
  } clr_state_e;

  // Address width for a register file of 'depth' entries; never below 1 bit
  // so that degenerate configurations still elaborate.
  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// -----------------------------------------------------------------------------
// regfile_clr_fsm
//   Sequential bulk-clear engine for regfile_mp. Once started it walks an
//   index pointer across the register file, requesting one entry clear per
//   cycle, then raises a single-cycle done pulse.
//
// Ports
//   clk       in   clock, all state on posedge
//   rst_n     in   synchronous active-low reset (FSM -> CLR_IDLE)
//   clr_req   in   start request; honoured in CLR_IDLE and CLR_DONE
//   clr_busy  out  1 while the sweep is running (CLR_RUN)
//   clr_done  out  1-cycle pulse after the last entry has been cleared
//   clr_we    out  clear strobe for entry clr_idx this cycle
//   clr_idx   out  entry being cleared this cycle
// -----------------------------------------------------------------------------
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter  int DEPTH    = 32,
  parameter  int ZERO_REG = 1,
  localparam int AW       = addr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          clr_we,
  output logic [AW-1:0] clr_idx
);

  // Entry 0 is never written when it is hardwired to zero, so the sweep
  // skips it and takes DEPTH-1 cycles instead of DEPTH.
  localparam logic [AW-1:0] START_IDX = (ZERO_REG != 0) ? AW'(1) : '0;
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] ptr_q,   ptr_d;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    clr_busy = 1'b0;
    clr_done = 1'b0;
    clr_we   = 1'b0;

    case (state_q)
      CLR_IDLE: begin
        if (clr_req) begin
          state_d = CLR_RUN;
          ptr_d   = START_IDX;
        end
      end

      CLR_RUN: begin
        clr_busy = 1'b1;
        clr_we   = 1'b1;
        // Terminal test on the last index: the pointer never wraps.
        if (ptr_q == LAST_IDX) begin
          state_d = CLR_DONE;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end

      CLR_DONE: begin
        clr_done = 1'b1;
        // A request arriving on the done cycle starts a fresh sweep
        // immediately rather than being lost.
        if (clr_req) begin
          state_d = CLR_RUN;
          ptr_d   = START_IDX;
        end else begin
          state_d = CLR_IDLE;
        end
      end

      default: begin
        state_d = CLR_IDLE;
      end
    endcase
  end

  assign clr_idx = ptr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLR_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//   Parametrised multi-port integer register file with combinational reads,
//   prioritised multi-port writes, optional hardwired-zero entry 0 and a
//   sequential bulk-clear engine (regfile_clr_fsm).
//
// Parameters
//   DATA_W    register width
//   DEPTH     number of registers (power of 2, >= 4)
//   NRD       number of combinational read ports
//   NWR       number of write ports (1..MAX_NWR); higher index wins
//   ZERO_REG  1: entry 0 reads as 0 and ignores writes
//
// Ports
//   clk       in   clock
//   rst_n     in   synchronous active-low reset; clears every entry at once
//   rs_addr   in   read addresses, port i at [i*AW +: AW]
//   rs_data   out  read data, port i at [i*DATA_W +: DATA_W]
//   wr_en     in   write enables, one per write port
//   wr_addr   in   write addresses, port k at [k*AW +: AW]
//   wr_data   in   write data, port k at [k*DATA_W +: DATA_W]
//   wr_ready  out  writes are accepted this cycle (not sweeping)
//   clr_req   in   request a bulk clear
//   clr_busy  out  bulk clear in progress
//   clr_done  out  1-cycle pulse when the bulk clear has finished
//
// Build option
//   REGFILE_BYPASS_EN  when defined, a read whose address matches an
//                      accepted write this cycle returns that write's data
//                      (winning port). When undefined, new data becomes
//                      visible on the cycle after the write.
// -----------------------------------------------------------------------------
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int DEPTH    = 32,
  parameter  int NRD      = 2,
  parameter  int NWR      = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = addr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD*AW-1:0]     rs_addr,
  output logic [NRD*DATA_W-1:0] rs_data,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*AW-1:0]     wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done
);

  if (NWR < 1 || NWR > MAX_NWR) begin : g_bad_nwr
    $error("regfile_mp: NWR must be in 1..%0d", MAX_NWR);
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic              clr_we;
  logic [AW-1:0]     clr_idx;

  regfile_clr_fsm #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_clr_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_idx  (clr_idx)
  );

  // The sweep owns the array while it runs; writers are stalled.
  assign wr_ready = !clr_busy;

  // Next-state of the storage. Ports are applied in ascending index order so
  // that the highest-index enabled port to the same address lands last and
  // wins. Clear strobes and accepted writes never coincide because writes
  // are only accepted while the sweep is idle.
  always_comb begin
    mem_d = mem_q;

    if (clr_we) begin
      mem_d[clr_idx] = '0;
    end

    for (int k = 0; k < NWR; k++) begin
      if (wr_en[k] && wr_ready &&
          !((ZERO_REG != 0) && (wr_addr[k*AW +: AW] == '0))) begin
        mem_d[wr_addr[k*AW +: AW]] = wr_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Reset clears the whole array in a single cycle and overrides any sweep
  // or write in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Combinational read ports.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_val;

    always_comb begin
      rd_addr = rs_addr[i*AW +: AW];
      rd_val  = mem_q[rd_addr];
`ifdef REGFILE_BYPASS_EN
      // Ascending scan mirrors the write priority: the last matching
      // accepted write is the one that will actually be stored.
      for (int k = 0; k < NWR; k++) begin
        if (wr_en[k] && wr_ready && (wr_addr[k*AW +: AW] == rd_addr)) begin
          rd_val = wr_data[k*DATA_W +: DATA_W];
        end
      end
`endif
      // Entry 0 reads as zero even if a bypass matched it.
      if ((ZERO_REG != 0) && (rd_addr == '0)) begin
        rd_val = '0;
      end
    end

    assign rs_data[i*DATA_W +: DATA_W] = rd_val;
  end

endmodule

// File: tb/tb_regfile_mp.sv
`timescale 1ns/1ps
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int NWR   = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*DW-1:0]   rs_data;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*DW-1:0]   wr_data;
  logic                wr_ready, clr_req, clr_busy, clr_done;

  // Second instance: entry 0 is an ordinary register.
  logic [AW-1:0]       z_rs_addr;
  logic [DW-1:0]       z_rs_data;
  logic                z_wr_en;
  logic [AW-1:0]       z_wr_addr;
  logic [DW-1:0]       z_wr_data;
  logic                z_wr_ready, z_clr_busy, z_clr_done;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .DEPTH(DEPTH), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rs_data(rs_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done));

  regfile_mp #(.DATA_W(DW), .DEPTH(DEPTH), .NRD(1), .NWR(1), .ZERO_REG(0)) u_dut_z0 (
    .clk(clk), .rst_n(rst_n), .rs_addr(z_rs_addr), .rs_data(z_rs_data),
    .wr_en(z_wr_en), .wr_addr(z_wr_addr), .wr_data(z_wr_data), .wr_ready(z_wr_ready),
    .clr_req(1'b0), .clr_busy(z_clr_busy), .clr_done(z_clr_done));

  // ---------------- reference model (ZERO_REG=1 instance) ----------------
  // m_rem: number of sweep cycles still to run; the entry cleared on a sweep
  // cycle is DEPTH - m_rem, so a fresh sweep starts at entry 1.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_rem  = 0;
  bit            m_done = 1'b0;
  int            n_chk  = 0;
  int            n_pass = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      foreach (m_mem[i]) m_mem[i] <= '0;
      m_rem  <= 0;
      m_done <= 1'b0;
    end else if (m_rem > 0) begin
      m_mem[DEPTH - m_rem] <= '0;
      m_rem  <= m_rem - 1;
      m_done <= (m_rem == 1);
    end else begin
      for (int k = 0; k < NWR; k++)
        if (wr_en[k] && wr_addr[k*AW +: AW] != 0)
          m_mem[wr_addr[k*AW +: AW]] <= wr_data[k*DW +: DW];
      m_done <= 1'b0;
      if (clr_req) m_rem <= DEPTH - 1;
    end
  end

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = m_mem[a];
`ifdef REGFILE_BYPASS_EN
    if (m_rem == 0)
      for (int k = 0; k < NWR; k++)
        if (wr_en[k] && wr_addr[k*AW +: AW] == a) v = wr_data[k*DW +: DW];
`endif
    if (a == 0) v = '0;
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NRD; i++)
      check($sformatf("%s rd%0d a%0d", tag, i, rs_addr[i*AW +: AW]),
            rs_data[i*DW +: DW], exp_rd(rs_addr[i*AW +: AW]));
    check({tag, " wr_ready"}, wr_ready, m_rem == 0);
    check({tag, " clr_busy"}, clr_busy, m_rem > 0);
    check({tag, " clr_done"}, clr_done, m_done);
  endtask

  // Inputs are set just after a falling edge; outputs checked 1ns later.
  task automatic settle(input string tag);
    #1 check_all(tag);
  endtask

  task automatic adv();
    @(negedge clk);
  endtask

  task automatic set_wr(input int k, input int a, input logic [DW-1:0] d);
    wr_en[k]          = 1'b1;
    wr_addr[k*AW +: AW] = AW'(a);
    wr_data[k*DW +: DW] = d;
  endtask

  int  busy_cycles, done_cnt;
  bit  seen;

  initial begin
    rst_n = 1'b0; clr_req = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0; rs_addr = '0;
    z_rs_addr = '0; z_wr_en = 1'b0; z_wr_addr = '0; z_wr_data = '0;
    adv();
    rst_n = 1'b1;

    // 1: everything reads zero after reset
    for (int a = 0; a < DEPTH; a++) begin
      rs_addr = {AW'(DEPTH - 1 - a), AW'(a)};
      z_rs_addr = AW'(a);
      settle("t1");
      check("t1 z0 rd", z_rs_data, 0);
      adv();
    end
    check("t1 wr_ready", wr_ready, 1);
    check("t1 clr_busy", clr_busy, 0);

    // 2: same-address write on both ports, port 1 wins
    set_wr(0, 5, 32'h11); set_wr(1, 5, 32'h22);
    settle("t2 wr"); adv();
    wr_en = '0; rs_addr = {AW'(0), AW'(5)};
    settle("t2 rd");
    check("t2 prio", rs_data[DW-1:0], 32'h22);
    adv();

    // 3: entry 0 write, hardwired vs ordinary
    set_wr(0, 0, 32'hDEADBEEF);
    z_wr_en = 1'b1; z_wr_addr = '0; z_wr_data = 32'hDEADBEEF;
    settle("t3 wr"); adv();
    wr_en = '0; z_wr_en = 1'b0; rs_addr = '0; z_rs_addr = '0;
    settle("t3 rd");
    check("t3 zr1 a0", rs_data[DW-1:0], 0);
    check("t3 zr0 a0", z_rs_data, 32'hDEADBEEF);
    adv();

    // 4: fill 1..31, bulk clear, write during sweep dropped
    for (int i = 1; i < DEPTH; i++) begin
      wr_en = '0; set_wr(0, i, DW'(i)); rs_addr = {AW'(i - 1), AW'(i)};
      settle("t4 fill"); adv();
    end
    wr_en = '0; clr_req = 1'b1;
    settle("t4 req"); adv();
    clr_req = 1'b0;
    busy_cycles = 0; done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      wr_en = '0;
      if (c == 5) set_wr(0, 3, 32'h77);
      rs_addr = {AW'($urandom_range(0, DEPTH - 1)), AW'(3)};
      settle("t4 sweep");
      if (clr_busy) busy_cycles++;
      if (clr_done) done_cnt++;
      adv();
    end
    check("t4 busy cycles", busy_cycles, 31);
    check("t4 done pulses", done_cnt, 1);
    wr_en = '0;
    for (int a = 0; a < DEPTH; a++) begin
      rs_addr = {AW'(DEPTH - 1 - a), AW'(a)};
      settle("t4 after");
      check("t4 zero p0", rs_data[DW-1:0], 0);
      check("t4 zero p1", rs_data[2*DW-1:DW], 0);
      adv();
    end

    // 5: reset in the middle of a sweep
    set_wr(0, 9, 32'hCAFE); set_wr(1, 20, 32'hBEEF);
    settle("t5 pre"); adv();
    wr_en = '0; clr_req = 1'b1;
    settle("t5 req"); adv();
    clr_req = 1'b0;
    for (int c = 0; c < 10; c++) begin settle("t5 sweep"); adv(); end
    rst_n = 1'b0;
    settle("t5 rst"); adv();
    rst_n = 1'b1; rs_addr = {AW'(20), AW'(9)};
    settle("t5 post");
    check("t5 busy", clr_busy, 0);
    check("t5 a9", rs_data[DW-1:0], 0);
    check("t5 a20", rs_data[2*DW-1:DW], 0);
    adv();
    settle("t5 idle"); adv();

    // 6: write and read the same entry in one cycle
    set_wr(0, 7, 32'h1234);
    settle("t6 pre"); adv();
    set_wr(0, 7, 32'hA5A5A5A5); rs_addr = {AW'(0), AW'(7)};
    settle("t6 same");
`ifdef REGFILE_BYPASS_EN
    check("t6 same cycle", rs_data[DW-1:0], 32'hA5A5A5A5);
`else
    check("t6 same cycle", rs_data[DW-1:0], 32'h1234);
`endif
    adv();
    wr_en = '0;
    settle("t6 next");
    check("t6 next cycle", rs_data[DW-1:0], 32'hA5A5A5A5);
    adv();

    // 7: request on the done cycle restarts the sweep
    clr_req = 1'b1;
    settle("t7 req"); adv();
    clr_req = 1'b0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      settle("t7 wait");
      if (clr_done) begin seen = 1'b1; clr_req = 1'b1; end
      adv();
    end
    check("t7 done seen", seen, 1);
    clr_req = 1'b0;
    settle("t7 restart");
    check("t7 restart busy", clr_busy, 1);
    adv();

    // random traffic
    for (int c = 0; c < 600; c++) begin
      rst_n   = ($urandom_range(0, 199) != 0);
      clr_req = ($urandom_range(0, 49) == 0);
      wr_en   = NWR'($urandom_range(0, 3));
      for (int k = 0; k < NWR; k++) begin
        wr_addr[k*AW +: AW] = AW'($urandom_range(0, 7));
        wr_data[k*DW +: DW] = $urandom;
      end
      for (int i = 0; i < NRD; i++)
        rs_addr[i*AW +: AW] = ($urandom_range(0, 1) == 1) ? wr_addr[AW-1:0]
                                                          : AW'($urandom_range(0, 7));
      settle("rnd"); adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
